// File: rtl/jt12_regwr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jt12_regwr_pkg
// Description : Shared definitions for the JT12 register-write sequencer:
//               request entry layout, FSM state encoding and a counter-width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package jt12_regwr_pkg;

    // One queued request: {part, reg, val} packed MSB first.
    localparam int ENTRY_W = 17;

    typedef struct packed {
        logic       part;   // [16]
        logic [7:0] regn;   // [15:8]
        logic [7:0] val;    // [7:0]
    } entry_t;

    // Sequencer states
    localparam int              ST_W    = 3;
    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_ADDR = 3'd1;
    localparam logic [ST_W-1:0] ST_GAP  = 3'd2;
    localparam logic [ST_W-1:0] ST_DATA = 3'd3;
    localparam logic [ST_W-1:0] ST_REL  = 3'd4;
    localparam logic [ST_W-1:0] ST_WAIT = 3'd5;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt12_regwr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : jt12_regwr_fifo
// Description : Synchronous request FIFO, depth 2**DEPTH_AW. Pointers carry
//               one extra MSB so full and empty are distinguishable when the
//               low bits match. Read data is the current head (show-ahead).
// Ports       : clk, rst          clock / synchronous active-high reset
//               push, din         write request and data (ignored when full)
//               pop, dout         read request (ignored when empty), head data
//               full, empty       status flags
//               level             number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module jt12_regwr_fifo #(
    parameter int DEPTH_AW = 4,
    parameter int WIDTH    = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [WIDTH-1:0]    din,
    input  logic                pop,
    output logic [WIDTH-1:0]    dout,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_AW:0]   level
);

    logic [WIDTH-1:0]   r_mem [2**DEPTH_AW];
    logic [DEPTH_AW:0]  r_wptr;
    logic [DEPTH_AW:0]  r_rptr;
    logic               w_push;
    logic               w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop  & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[DEPTH_AW-1:0]] <= din;
    end

    assign dout  = r_mem[r_rptr[DEPTH_AW-1:0]];
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[DEPTH_AW] != r_rptr[DEPTH_AW]) &&
                   (r_wptr[DEPTH_AW-1:0] == r_rptr[DEPTH_AW-1:0]);
    assign level = r_wptr - r_rptr;

endmodule
`default_nettype wire

// File: rtl/jt12_regwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : jt12_regwr_seq
// Description : Host-side write sequencer for the JT12 CPU register port.
//               Queues {part,reg,val} writes and replays each as an address
//               bus cycle followed by a data bus cycle, then waits for the
//               chip busy flag to clear (bounded by BUSY_TMO). The address
//               cycle is skipped when the chip already has that register
//               selected (ADDR_SKIP=1).
// Ports       : clk, rst                     clock / sync active-high reset
//               req_valid/ready, req_part,
//               req_reg, req_val             request push interface
//               fifo_level, idle, tmo_err    status
//               chip_addr, chip_din,
//               chip_write, chip_busy        JT12 CPU port (outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module jt12_regwr_seq
    import jt12_regwr_pkg::*;
#(
    parameter int FIFO_AW   = 4,
    parameter int WR_LEN    = 2,
    parameter int GAP_LEN   = 1,
    parameter int BUSY_TMO  = 1024,
    parameter int ADDR_SKIP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_part,
    input  logic [7:0]          req_reg,
    input  logic [7:0]          req_val,
    output logic [FIFO_AW:0]    fifo_level,
    output logic                idle,
    output logic                tmo_err,
    output logic [1:0]          chip_addr,
    output logic [7:0]          chip_din,
    output logic                chip_write,
    input  logic                chip_busy
);

    localparam int PH_W = cnt_w((WR_LEN > GAP_LEN) ? WR_LEN : GAP_LEN);
    localparam int TM_W = cnt_w(BUSY_TMO);

    localparam logic [PH_W-1:0] c_WR_LAST  = PH_W'(WR_LEN - 1);
    localparam logic [PH_W-1:0] c_GAP_LAST = PH_W'(GAP_LEN - 1);
    localparam logic [TM_W-1:0] c_TMO_LAST = TM_W'(BUSY_TMO - 1);

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_skip;
    logic [ENTRY_W-1:0] w_head_raw;
    entry_t             w_head;

    logic [ST_W-1:0]    r_state;
    logic [PH_W-1:0]    r_ph;       // bus-phase counter (write / gap length)
    logic [TM_W-1:0]    r_wt;       // busy wait counter
    entry_t             r_work;
    logic [8:0]         r_cache;    // {part, reg} currently latched in the chip
    logic               r_cache_vld;
    logic               r_chip_write;
    logic [1:0]         r_chip_addr;
    logic [7:0]         r_chip_din;
    logic               r_tmo_err;

    jt12_regwr_fifo #(
        .DEPTH_AW (FIFO_AW),
        .WIDTH    (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid),
        .din   ({req_part, req_reg, req_val}),
        .pop   (w_pop),
        .dout  (w_head_raw),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    assign w_head = entry_t'(w_head_raw);

    // Pop happens in the single IDLE cycle; the FSM leaves IDLE on the same
    // edge, so consecutive entries cost exactly one IDLE cycle each.
    assign w_pop  = (r_state == ST_IDLE) && !w_empty;

    assign w_skip = (ADDR_SKIP != 0) && r_cache_vld &&
                    (r_cache == {w_head.part, w_head.regn});

    // Bus outputs are loaded on the transition into each phase so that they
    // stay registered and the strobe rises one cycle after the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ph         <= '0;
            r_wt         <= '0;
            r_work       <= '0;
            r_cache      <= '0;
            r_cache_vld  <= 1'b0;
            r_chip_write <= 1'b0;
            r_chip_addr  <= 2'b00;
            r_chip_din   <= 8'h00;
            r_tmo_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_work       <= w_head;
                        r_ph         <= '0;
                        r_chip_write <= 1'b1;
                        if (w_skip) begin
                            r_state     <= ST_DATA;
                            r_chip_addr <= {w_head.part, 1'b1};
                            r_chip_din  <= w_head.val;
                        end else begin
                            r_state     <= ST_ADDR;
                            r_chip_addr <= {w_head.part, 1'b0};
                            r_chip_din  <= w_head.regn;
                        end
                    end
                end
                ST_ADDR: begin
                    if (r_ph == c_WR_LAST) begin
                        r_cache      <= {r_work.part, r_work.regn};
                        r_cache_vld  <= 1'b1;
                        r_chip_write <= 1'b0;
                        r_ph         <= '0;
                        r_state      <= ST_GAP;
                    end else begin
                        r_ph <= r_ph + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_ph == c_GAP_LAST) begin
                        r_chip_write <= 1'b1;
                        r_chip_addr  <= {r_work.part, 1'b1};
                        r_chip_din   <= r_work.val;
                        r_ph         <= '0;
                        r_state      <= ST_DATA;
                    end else begin
                        r_ph <= r_ph + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_ph == c_WR_LAST) begin
                        r_chip_write <= 1'b0;
                        r_ph         <= '0;
                        r_state      <= ST_REL;
                    end else begin
                        r_ph <= r_ph + 1'b1;
                    end
                end
                ST_REL: begin
                    // Busy from the chip lags the strobe; it is not trusted here.
                    r_wt    <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!chip_busy) begin
                        r_state <= ST_IDLE;
                    end else if (r_wt == c_TMO_LAST) begin
                        r_tmo_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_wt <= r_wt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = ~w_full;
    assign idle       = (r_state == ST_IDLE) && w_empty;
    assign tmo_err    = r_tmo_err;
    assign chip_write = r_chip_write;
    assign chip_addr  = r_chip_addr;
    assign chip_din   = r_chip_din;

endmodule
`default_nettype wire
